fluxo_dados_rodada: RTL and testbench

//  Parametrised successor of the game datapath: selects a game seed by button presses,

---
 rtl/fluxo_dados_rodada.sv | 155 +++++++++++++++
 tb/tb_fluxo_dados_rodada.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_rodada.sv
// Round datapath: seed select by button, seed word fetch from external ROM, alive-player walk.
// Player pointer moves one cycle after avanca/nova_rodada; pulse-driven, no backpressure.
module fluxo_dados_rodada #(
  parameter int N_JOG    = 5,
  parameter int W_CLASSE = 2,
  parameter int N_SEEDS  = 20,
  parameter int W_ADDR   = 5,
  parameter int W_JOG    = 3
) (
  input  logic                        clock,
  input  logic                        rst_global_n,
  input  logic                        botao,
  input  logic                        zera_seed,
  input  logic                        iniciar,
  input  logic                        avanca,
  input  logic                        nova_rodada,
  input  logic                        elimina,
  input  logic [W_JOG-1:0]            elimina_idx,
  output logic [W_ADDR-1:0]           seed_addr,
  input  logic [N_JOG*W_CLASSE-1:0]   seed_dado,
  output logic [N_JOG*W_CLASSE-1:0]   jogo_atual,
  output logic [W_JOG-1:0]            jogador_atual,
  output logic [W_CLASSE-1:0]         classe_atual,
  output logic                        valido,
  output logic                        fim,
  output logic [N_JOG-1:0]            vivos,
  output logic [W_JOG-1:0]            n_vivos,
  output logic [1:0]                  db_estado
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, REVEAL = 2'd2, DONE = 2'd3} estado_t;

  estado_t                     estado_q, estado_d;
  logic                        botao_q, botao_d;
  logic [W_ADDR-1:0]           addr_q, addr_d;
  logic [N_JOG*W_CLASSE-1:0]   jogo_q, jogo_d;
  logic [W_JOG-1:0]            jog_q, jog_d;
  logic [N_JOG-1:0]            vivos_q, vivos_d, vivos_elim;
  logic                        prox_ok, prim_ok;
  logic [W_JOG-1:0]            prox_idx, prim_idx;
  logic [W_JOG-1:0]            cnt;
  logic [W_CLASSE-1:0]         classe;

  // Elimination only after a word has been loaded; out-of-range indices match no bit.
  always_comb begin
    vivos_elim = vivos_q;
    if (elimina && (estado_q == REVEAL || estado_q == DONE)) begin
      for (int j = 0; j < N_JOG; j++) begin
        if (elimina_idx == W_JOG'(j)) vivos_elim[j] = 1'b0;
      end
    end
  end

  // Searches run on the post-elimination mask so a same-cycle elimina is honoured.
  always_comb begin
    prox_ok  = 1'b0;
    prox_idx = jog_q;
    prim_ok  = 1'b0;
    prim_idx = '0;
    for (int j = N_JOG - 1; j >= 0; j--) begin
      if (vivos_elim[j]) begin
        prim_ok  = 1'b1;
        prim_idx = W_JOG'(j);
        if (W_JOG'(j) > jog_q) begin
          prox_ok  = 1'b1;
          prox_idx = W_JOG'(j);
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int j = 0; j < N_JOG; j++) cnt = cnt + W_JOG'(vivos_q[j]);
  end

  always_comb begin
    classe = '0;
    for (int j = 0; j < N_JOG; j++) begin
      if (jog_q == W_JOG'(j)) classe = jogo_q[j*W_CLASSE +: W_CLASSE];
    end
  end

  always_comb begin
    estado_d = estado_q;
    botao_d  = botao;
    addr_d   = addr_q;
    jogo_d   = jogo_q;
    jog_d    = jog_q;
    vivos_d  = vivos_elim;
    case (estado_q)
      IDLE: begin
        if (zera_seed) begin
          addr_d = '0;
        end else if (botao && !botao_q) begin
          addr_d = (addr_q == W_ADDR'(N_SEEDS - 1)) ? '0 : addr_q + W_ADDR'(1);
        end
        if (iniciar) estado_d = LOAD;
      end
      LOAD: begin
        jogo_d   = seed_dado;
        vivos_d  = '1;
        jog_d    = '0;
        estado_d = REVEAL;
      end
      REVEAL: begin
        if (nova_rodada) begin
          if (prim_ok) jog_d = prim_idx;
          else         estado_d = DONE;
        end else if (!prim_ok) begin
          estado_d = DONE;
        end else if (avanca) begin
          if (prox_ok) jog_d = prox_idx;
          else         estado_d = DONE;
        end
      end
      DONE: begin
        if (nova_rodada && prim_ok) begin
          jog_d    = prim_idx;
          estado_d = REVEAL;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_global_n) begin
      estado_q <= IDLE;
      botao_q  <= 1'b0;
      addr_q   <= '0;
      jogo_q   <= '0;
      jog_q    <= '0;
      vivos_q  <= '1;
    end else begin
      estado_q <= estado_d;
      botao_q  <= botao_d;
      addr_q   <= addr_d;
      jogo_q   <= jogo_d;
      jog_q    <= jog_d;
      vivos_q  <= vivos_d;
    end
  end

  assign seed_addr     = addr_q;
  assign jogo_atual    = jogo_q;
  assign jogador_atual = jog_q;
  assign classe_atual  = classe;
  assign valido        = (estado_q == REVEAL);
  assign fim           = (estado_q == DONE);
  assign vivos         = vivos_q;
  assign n_vivos       = cnt;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_fluxo_dados_rodada.sv
// Directed bench for fluxo_dados_rodada with a synchronous seed ROM model.
module tb_fluxo_dados_rodada;

  logic        clock = 1'b0;
  logic        rst_global_n, botao, zera_seed, iniciar, avanca, nova_rodada, elimina;
  logic [2:0]  elimina_idx;
  logic [4:0]  seed_addr;
  logic [9:0]  seed_dado;
  logic [9:0]  jogo_atual;
  logic [2:0]  jogador_atual;
  logic [1:0]  classe_atual;
  logic        valido, fim;
  logic [4:0]  vivos;
  logic [2:0]  n_vivos;
  logic [1:0]  db_estado;

  logic [9:0]  rom [20];
  int          n_checks = 0;
  int          n_errors = 0;

  fluxo_dados_rodada dut (
    .clock(clock), .rst_global_n(rst_global_n), .botao(botao), .zera_seed(zera_seed),
    .iniciar(iniciar), .avanca(avanca), .nova_rodada(nova_rodada), .elimina(elimina),
    .elimina_idx(elimina_idx), .seed_addr(seed_addr), .seed_dado(seed_dado),
    .jogo_atual(jogo_atual), .jogador_atual(jogador_atual), .classe_atual(classe_atual),
    .valido(valido), .fim(fim), .vivos(vivos), .n_vivos(n_vivos), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) seed_dado <= rom[seed_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press();
    botao = 1'b1; tick();
    botao = 1'b0; tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_estado"}, db_estado, 0);
    check({tag, "_addr"},   seed_addr, 0);
    check({tag, "_jogo"},   jogo_atual, 0);
    check({tag, "_jog"},    jogador_atual, 0);
    check({tag, "_vivos"},  vivos, 5'b11111);
    check({tag, "_nvivos"}, n_vivos, 5);
    check({tag, "_valido"}, valido, 0);
    check({tag, "_fim"},    fim, 0);
  endtask

  logic [1:0] exp_cls [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    for (int i = 0; i < 20; i++) rom[i] = 10'(i * 41 + 7);
    rom[3] = 10'b11_10_01_00_00;
    rst_global_n = 1'b0; botao = 0; zera_seed = 0; iniciar = 0; avanca = 0;
    nova_rodada = 0; elimina = 0; elimina_idx = '0;
    tick(); tick();
    rst_global_n = 1'b1;
    check_reset("rst");

    for (int i = 0; i < 3; i++) press();
    check("addr3", seed_addr, 3);
    iniciar = 1; tick(); iniciar = 0;
    check("load_estado", db_estado, 1);
    tick();
    check("rev_estado", db_estado, 2);
    check("rev_jogo", jogo_atual, 10'b11_10_01_00_00);
    check("rev_valido", valido, 1);
    check("rev_jog0", jogador_atual, 0);
    check("rev_cls0", classe_atual, 0);
    for (int k = 1; k < 5; k++) begin
      avanca = 1; tick(); avanca = 0;
      check("walk_jog", jogador_atual, k);
      check("walk_cls", classe_atual, exp_cls[k]);
    end
    avanca = 1; tick(); avanca = 0;
    check("done_estado", db_estado, 3);
    check("done_fim", fim, 1);
    check("done_valido", valido, 0);
    check("done_jog", jogador_atual, 4);
    press();
    check("addr_frozen", seed_addr, 3);
    iniciar = 1; tick(); iniciar = 0;
    check("iniciar_ign", db_estado, 3);

    nova_rodada = 1; tick(); nova_rodada = 0;
    check("nr_estado", db_estado, 2);
    check("nr_jog", jogador_atual, 0);
    avanca = 1; tick(); avanca = 0;
    check("jog1", jogador_atual, 1);
    elimina = 1; elimina_idx = 3'd2; avanca = 1; tick(); elimina = 0; avanca = 0;
    check("skip_jog", jogador_atual, 3);
    check("skip_vivos", vivos, 5'b11011);
    check("skip_nvivos", n_vivos, 4);
    elimina = 1; elimina_idx = 3'd3; tick(); elimina = 0;
    check("elcur_jog", jogador_atual, 3);
    check("elcur_cls", classe_atual, 2);
    check("elcur_nvivos", n_vivos, 3);
    avanca = 1; tick(); avanca = 0;
    check("jog4", jogador_atual, 4);
    elimina = 1; elimina_idx = 3'd6; tick(); elimina = 0;
    check("idx6_vivos", vivos, 5'b10011);
    nova_rodada = 1; avanca = 1; tick(); nova_rodada = 0; avanca = 0;
    check("nr_beats_av", jogador_atual, 0);
    elimina = 1; elimina_idx = 3'd0; tick(); elimina = 0;
    check("el0_estado", db_estado, 2);
    nova_rodada = 1; tick(); nova_rodada = 0;
    check("nr_jog1", jogador_atual, 1);
    elimina = 1; elimina_idx = 3'd1; tick();
    elimina_idx = 3'd4; tick(); elimina = 0;
    check("all_estado", db_estado, 3);
    check("all_vivos", vivos, 0);
    check("all_nvivos", n_vivos, 0);
    check("all_fim", fim, 1);
    nova_rodada = 1; tick(); nova_rodada = 0;
    check("all_nr_estado", db_estado, 3);

    rst_global_n = 1'b0; tick(); rst_global_n = 1'b1;
    check_reset("rst2");
    for (int i = 0; i < 21; i++) press();
    check("wrap_addr", seed_addr, 1);
    zera_seed = 1; botao = 1; tick(); zera_seed = 0; botao = 0; tick();
    check("zera_addr", seed_addr, 0);
    iniciar = 1; tick(); iniciar = 0; tick();
    check("rom0_jogo", jogo_atual, 7);
    check("rom0_cls", classe_atual, 3);
    avanca = 1; tick(); avanca = 0;
    check("rom0_cls1", classe_atual, 1);
    rst_global_n = 1'b0; tick(); rst_global_n = 1'b1;
    check_reset("rst3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
